// File: rtl/mem_lsu.sv
// Load/store unit for the MEM stage: turns LOAD/STORE into a single-outstanding
// data-memory access (IDLE -> BUSY -> DONE) and forwards non-memory ops with no added latency.
module mem_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd_addr_i,
    input  logic        wreg_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] store_data_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    output logic [7:0]  mem_wstrb_o,
    input  logic        mem_ack_i,
    input  logic [63:0] mem_rdata_i,
    output logic [4:0]  rd_addr_o,
    output logic        wreg_o,
    output logic [63:0] wdata_o,
    output logic        stall_req_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t      state_reg;
    logic [15:0] cnt_reg;
    logic [63:0] load_res_reg;
    logic        err_reg;

    // Access captured on IDLE->BUSY so the bus stays stable whatever upstream does.
    logic [63:0] addr_reg;
    logic        we_reg;
    logic [7:0]  wstrb_reg;
    logic [63:0] st_wdata_reg;
    logic [2:0]  f3_reg;
    logic [2:0]  off_reg;
    logic [4:0]  rd_reg;
    logic        wreg_reg;
    logic [63:0] wdata_reg;

    logic        is_load;
    logic        is_store;
    logic        is_mem_opc;
    logic        misaligned;
    logic        go_mem;
    logic [3:0]  nbytes;
    logic [3:0]  lane_lo;
    logic [3:0]  lane_hi;
    logic [7:0]  lane_strb;
    logic [63:0] st_wdata;
    logic [63:0] aligned_addr;
    logic [63:0] rdata_shifted;
    logic [63:0] load_ext;
    logic        timeout_hit;

    // Decode of the instruction sitting in EX/MEM
    assign is_mem_opc = (opcode_i == OPC_LOAD) || (opcode_i == OPC_STORE);
    assign is_load    = (opcode_i == OPC_LOAD) && (funct3_i != 3'b111);
    assign is_store   = (opcode_i == OPC_STORE) && !funct3_i[2];

    always_comb begin
        nbytes     = 4'd8;
        misaligned = 1'b0;
        case (funct3_i[1:0])
            2'b00: nbytes = 4'd1;
            2'b01: begin
                nbytes     = 4'd2;
                misaligned = wdata_i[0];
            end
            2'b10: begin
                nbytes     = 4'd4;
                misaligned = |wdata_i[1:0];
            end
            default: begin
                nbytes     = 4'd8;
                misaligned = |wdata_i[2:0];
            end
        endcase
    end

    assign go_mem       = (is_load || is_store) && !misaligned;
    assign aligned_addr = {wdata_i[63:3], 3'b000};
    assign st_wdata     = store_data_i << {wdata_i[2:0], 3'b000};
    assign lane_lo      = {1'b0, wdata_i[2:0]};
    assign lane_hi      = lane_lo + nbytes;

    // A lane is written when it falls inside [offset, offset + size).
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            localparam logic [3:0] LANE = 4'(gi);
            assign lane_strb[gi] = (LANE >= lane_lo) && (LANE < lane_hi);
        end
    endgenerate

    assign rdata_shifted = mem_rdata_i >> {off_reg, 3'b000};

    always_comb begin
        load_ext = rdata_shifted;
        case (f3_reg)
            3'b000:  load_ext = {{56{rdata_shifted[7]}},  rdata_shifted[7:0]};
            3'b001:  load_ext = {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b010:  load_ext = {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
            3'b100:  load_ext = {56'd0, rdata_shifted[7:0]};
            3'b101:  load_ext = {48'd0, rdata_shifted[15:0]};
            3'b110:  load_ext = {32'd0, rdata_shifted[31:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    // cnt_reg counts BUSY cycles already completed; this cycle would be number cnt_reg+1.
    assign timeout_hit = (32'(cnt_reg) + 32'd1) >= TIMEOUT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 16'd0;
            load_res_reg <= 64'd0;
            err_reg      <= 1'b0;
            addr_reg     <= 64'd0;
            we_reg       <= 1'b0;
            wstrb_reg    <= 8'd0;
            st_wdata_reg <= 64'd0;
            f3_reg       <= 3'd0;
            off_reg      <= 3'd0;
            rd_reg       <= 5'd0;
            wreg_reg     <= 1'b0;
            wdata_reg    <= 64'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (go_mem) begin
                        state_reg    <= ST_BUSY;
                        cnt_reg      <= 16'd0;
                        err_reg      <= 1'b0;
                        addr_reg     <= aligned_addr;
                        we_reg       <= is_store;
                        wstrb_reg    <= is_store ? lane_strb : 8'd0;
                        st_wdata_reg <= st_wdata;
                        f3_reg       <= funct3_i;
                        off_reg      <= wdata_i[2:0];
                        rd_reg       <= rd_addr_i;
                        wreg_reg     <= wreg_i;
                        wdata_reg    <= wdata_i;
                    end
                end
                ST_BUSY: begin
                    cnt_reg <= cnt_reg + 16'd1;
                    if (mem_ack_i) begin
                        state_reg <= ST_DONE;
                        if (!we_reg) begin
                            load_res_reg <= load_ext;
                        end
                    end else if (timeout_hit) begin
                        state_reg <= ST_DONE;
                        err_reg   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    err_reg   <= 1'b0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_wstrb_o = 8'd0;
        mem_addr_o  = aligned_addr;
        mem_wdata_o = st_wdata;
        stall_req_o = 1'b0;
        misalign_o  = 1'b0;
        bus_err_o   = 1'b0;
        rd_addr_o   = rd_addr_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        if (rst) begin
            wreg_o = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (is_load || is_store) begin
                        wreg_o = 1'b0;
                        if (misaligned) begin
                            misalign_o = 1'b1;
                        end else begin
                            stall_req_o = 1'b1;
                            mem_we_o    = is_store;
                            mem_wstrb_o = is_store ? lane_strb : 8'd0;
                        end
                    end else if (is_mem_opc) begin
                        // Unsupported size encodings retire as harmless no-ops.
                        wreg_o = 1'b0;
                    end
                end
                ST_BUSY: begin
                    mem_req_o   = 1'b1;
                    stall_req_o = 1'b1;
                    mem_we_o    = we_reg;
                    mem_wstrb_o = wstrb_reg;
                    mem_addr_o  = addr_reg;
                    mem_wdata_o = st_wdata_reg;
                    rd_addr_o   = rd_reg;
                    wreg_o      = 1'b0;
                    wdata_o     = wdata_reg;
                end
                ST_DONE: begin
                    mem_addr_o  = addr_reg;
                    mem_wdata_o = st_wdata_reg;
                    bus_err_o   = err_reg;
                    rd_addr_o   = rd_reg;
                    if (err_reg || we_reg) begin
                        wreg_o  = 1'b0;
                        wdata_o = wdata_reg;
                    end else begin
                        wreg_o  = wreg_reg;
                        wdata_o = load_res_reg;
                    end
                end
                default: wreg_o = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomised scoreboard bench for mem_lsu: the driver pushes expected retirements and
// bus requests, and a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_lsu;

    localparam int TMO = 8;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ADDI  = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rd_addr_i;
    logic        wreg_i;
    logic [63:0] wdata_i;
    logic [63:0] store_data_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic        mem_ack_i;
    logic [63:0] mem_rdata_i;
    logic [4:0]  rd_addr_o;
    logic        wreg_o;
    logic [63:0] wdata_o;
    logic        stall_req_o;
    logic        misalign_o;
    logic        bus_err_o;

    mem_lsu #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .rd_addr_i(rd_addr_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .store_data_i(store_data_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .rd_addr_o(rd_addr_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stall_req_o(stall_req_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        wreg;
        logic [63:0] wdata;
        logic        mis;
        logic        err;
        int          stalls;
    } ret_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [7:0]  wstrb;
        logic [63:0] wdata;
        int          cycles;
    } req_t;

    ret_t ret_q[$];
    req_t req_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   done       = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: DUT output with nothing expected (t=%0t)", name, $time);
    endfunction

    function automatic int size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 8;
        endcase
    endfunction

    // Reference load: pick the addressed bytes, then sign- or zero-extend.
    function automatic logic [63:0] load_model(input logic [2:0] f3, input logic [2:0] off,
                                               input logic [63:0] rdata);
        logic [63:0] val;
        logic [63:0] mask;
        int          n;
        n   = size_bytes(f3);
        val = rdata >> (8 * int'(off));
        if (n == 8) return val;
        mask = (64'd1 << (8 * n)) - 64'd1;
        val  = val & mask;
        if (!f3[2] && val[8 * n - 1]) val = val | ~mask;
        return val;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and hold it for as many cycles as the spec says it occupies.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] sdata, input logic [4:0] rd, input logic wr,
                         input logic [63:0] rdata, input int wait_n);
        ret_t r;
        req_t q;
        bit   is_ld, is_st, mis;
        int   n, busy;
        is_ld = (op == LOAD) && (f3 != 3'b111);
        is_st = (op == STORE) && !f3[2];
        n     = size_bytes(f3);
        mis   = (is_ld || is_st) && ((int'(addr[2:0]) % n) != 0);
        opcode_i = op; funct3_i = f3; wdata_i = addr; store_data_i = sdata;
        rd_addr_i = rd; wreg_i = wr; mem_rdata_i = rdata; mem_ack_i = 1'b0;
        r.rd = rd; r.wreg = wr; r.wdata = addr; r.mis = 1'b0; r.err = 1'b0; r.stalls = 0;
        if (!(is_ld || is_st)) begin
            if (op == LOAD || op == STORE) r.wreg = 1'b0;
            ret_q.push_back(r);
            $display("issue op=%b f3=%0d addr=%h -> pass-through", op, f3, addr);
            step();
        end else if (mis) begin
            r.wreg = 1'b0;
            r.mis  = 1'b1;
            ret_q.push_back(r);
            $display("issue %s f3=%0d addr=%h -> misaligned", is_ld ? "LOAD" : "STORE", f3, addr);
            step();
        end else begin
            busy     = (wait_n < 0) ? TMO : wait_n + 1;
            q.addr   = {addr[63:3], 3'b000};
            q.we     = is_st;
            q.wstrb  = is_st ? 8'((((1 << n) - 1) << int'(addr[2:0])) & 255) : 8'd0;
            q.wdata  = sdata << (8 * int'(addr[2:0]));
            q.cycles = busy;
            req_q.push_back(q);
            r.stalls = 1 + busy;
            r.err    = (wait_n < 0);
            if (is_ld && wait_n >= 0) begin
                r.wdata = load_model(f3, addr[2:0], rdata);
            end else begin
                r.wreg = 1'b0;
            end
            ret_q.push_back(r);
            $display("issue %s f3=%0d addr=%h wait=%0d -> exp wreg=%0d wdata=%h err=%0d",
                     is_ld ? "LOAD" : "STORE", f3, addr, wait_n, r.wreg, r.wdata, r.err);
            step();
            for (int k = 1; k <= busy; k++) begin
                mem_ack_i = (k == wait_n + 1);
                step();
            end
            mem_ack_i = 1'b0;
            step();
        end
    endtask

    int   stall_cnt = 0;
    int   req_cnt   = 0;
    bit   prev_req  = 1'b0;

    always @(negedge clk) begin
        ret_t r;
        req_t q;
        if (!done) begin
            if (prev_req && !mem_req_o) begin
                if (req_q.size() == 0) begin
                    fail_now("req_end");
                end else begin
                    q = req_q.pop_front();
                    chk("req_cycles", 64'(req_cnt), 64'(q.cycles));
                end
                req_cnt = 0;
            end
            if (rst) begin
                chk("rst_outputs", {50'd0, mem_req_o, mem_we_o, mem_wstrb_o, stall_req_o,
                                    wreg_o, misalign_o, bus_err_o}, 64'd0);
                stall_cnt = 0;
            end else begin
                if (mem_req_o) begin
                    if (req_q.size() == 0) begin
                        fail_now("spurious_req");
                    end else begin
                        q = req_q[0];
                        chk("mem_addr", mem_addr_o, q.addr);
                        chk("mem_we", 64'(mem_we_o), 64'(q.we));
                        chk("mem_wstrb", 64'(mem_wstrb_o), 64'(q.wstrb));
                        if (q.we) chk("mem_wdata", mem_wdata_o, q.wdata);
                    end
                    req_cnt++;
                end
                if (stall_req_o) begin
                    stall_cnt++;
                    chk("flags_while_stalled", {62'd0, misalign_o, bus_err_o}, 64'd0);
                end else begin
                    if (ret_q.size() == 0) begin
                        fail_now("unexpected_retire");
                    end else begin
                        r = ret_q.pop_front();
                        chk("wreg", 64'(wreg_o), 64'(r.wreg));
                        chk("misalign", 64'(misalign_o), 64'(r.mis));
                        chk("bus_err", 64'(bus_err_o), 64'(r.err));
                        chk("stall_cycles", 64'(stall_cnt), 64'(r.stalls));
                        if (r.wreg) begin
                            chk("rd_addr", 64'(rd_addr_o), 64'(r.rd));
                            chk("wdata", wdata_o, r.wdata);
                        end
                    end
                    stall_cnt = 0;
                end
            end
            prev_req = mem_req_o;
        end
    end

    initial begin
        ret_t        r;
        req_t        q;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [63:0] addr;
        int          sel, wt;
        opcode_i = ADDI; funct3_i = 3'd0; wdata_i = 64'd0; store_data_i = 64'd0;
        rd_addr_i = 5'd0; wreg_i = 1'b0; mem_rdata_i = 64'd0; mem_ack_i = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        issue(LOAD,  3'b010, 64'h1004, 64'd0, 5'd3, 1'b1, 64'hFFFFFFFF_80000000, 0);
        issue(STORE, 3'b000, 64'h2003, 64'hAB, 5'd4, 1'b1, 64'd0, 0);
        issue(LOAD,  3'b101, 64'h3006, 64'd0, 5'd7, 1'b1, 64'h8001_0000_0000_0000, 4);
        issue(LOAD,  3'b011, 64'h4004, 64'd0, 5'd8, 1'b1, 64'd0, 0);
        issue(LOAD,  3'b010, 64'h5000, 64'd0, 5'd9, 1'b1, 64'h1234, -1);
        issue(ADDI,  3'b000, 64'h55, 64'd0, 5'd2, 1'b1, 64'd0, 0);

        // Reset lands on the second BUSY cycle; the late ack must be ignored.
        q.addr = 64'h6000; q.we = 1'b0; q.wstrb = 8'd0; q.wdata = 64'd0; q.cycles = 1;
        req_q.push_back(q);
        opcode_i = LOAD; funct3_i = 3'b010; wdata_i = 64'h6000; rd_addr_i = 5'd11; wreg_i = 1'b1;
        mem_rdata_i = 64'hDEAD_BEEF;
        $display("issue LOAD addr=6000 with reset during BUSY -> abandoned");
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        r.rd = 5'd10; r.wreg = 1'b1; r.wdata = 64'h77; r.mis = 1'b0; r.err = 1'b0; r.stalls = 0;
        ret_q.push_back(r);
        opcode_i = 7'b0110011; wdata_i = 64'h77; rd_addr_i = 5'd10; wreg_i = 1'b1; mem_ack_i = 1'b1;
        $display("issue OP after reset with stray ack -> pass-through");
        step();
        mem_ack_i = 1'b0;

        issue(LOAD, 3'b111, 64'h7000, 64'd0, 5'd12, 1'b1, 64'd0, 0);
        issue(ADDI, 3'b000, 64'd0, 64'd0, 5'd0, 1'b0, 64'd0, 0);

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                op = LOAD;
                f3 = 3'($urandom_range(0, 7));
            end else if (sel < 7) begin
                op = STORE;
                f3 = 3'($urandom_range(0, 3));
            end else begin
                op = 7'($urandom);
                if (op == LOAD || op == STORE) op = 7'b0110011;
                f3 = 3'($urandom_range(0, 7));
            end
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) addr = addr & ~64'd7;
            wt = ($urandom_range(0, 15) == 0) ? -1 : $urandom_range(0, 3);
            issue(op, f3, addr, {$urandom, $urandom}, 5'($urandom), 1'($urandom),
                  {$urandom, $urandom}, wt);
        end

        done = 1'b1;
        step();
        step();
        chk("ret_queue_drained", 64'(ret_q.size()), 64'd0);
        chk("req_queue_drained", 64'(req_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of BUSY cycles without mem_ack_i before a bus error is declared.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 rd_addr_i  input  5  destination register index, from the EX/MEM pipeline register.
REQ-005 wreg_i  input  1  destination register write enable, from EX/MEM.
REQ-006 wdata_i  input  64  ALU result; this is the effective address for loads and stores.
REQ-007 store_data_i  input  64  rs2 value, used as the store data.
REQ-008 opcode_i  input  7  instruction opcode: 7'b0000011 is LOAD, 7'b0100011 is STORE, any other value is non-memory.
REQ-009 funct3_i  input  3  access size and sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-010 mem_req_o  output  1  data-memory request.
REQ-011 mem_we_o  output  1  write request (store).
REQ-012 mem_addr_o  output  64  doubleword-aligned address, equal to wdata_i with bits [2:0] cleared.
REQ-013 mem_wdata_o  output  64  store data, shifted into its byte lanes.
REQ-014 mem_wstrb_o  output  8  byte-lane write strobes.
REQ-015 mem_ack_i  input  1  memory completion; for loads, mem_rdata_i is valid in the same cycle.
REQ-016 mem_rdata_i  input  64  raw doubleword returned by memory.
REQ-017 rd_addr_o, wreg_o, wdata_o  output  5/1/64  writeback fields sent to MEM/WB.
REQ-018 stall_req_o  output  1  request to the controller to apply CTRL_STATE_Block to the upstream stages.
REQ-019 misalign_o  output  1  flags a misaligned access.
REQ-020 bus_err_o  output  1  flags a memory timeout.

Function
REQ-021 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-022 IDLE transitions:
- aligned LOAD or STORE present: go to BUSY next cycle; stall_req_o=1 this cycle.
- otherwise: stay in IDLE.
REQ-023 BUSY behaviour:
- mem_req_o=1 and stall_req_o=1.
- mem_addr_o, mem_we_o, mem_wdata_o and mem_wstrb_o held stable.
- mem_ack_i=1: go to DONE.
REQ-024 BUSY timeout:
- a 16-bit counter SHALL clear on entry to BUSY and increment on each BUSY cycle.
- counter reaches TIMEOUT without ack: go to DONE with the error flag set.
REQ-025 DONE behaviour:
- stall_req_o=0.
- writeback outputs are presented for one cycle, then the FSM returns to IDLE.
REQ-026 Minimum memory-op latency is 3 cycles (IDLE, BUSY with ack, DONE); each extra wait cycle adds one.
REQ-027 Non-memory operations:
- processed in IDLE with zero added latency and stall_req_o=0.
- rd_addr_o=rd_addr_i, wreg_o=wreg_i, wdata_o=wdata_i, combinationally.
REQ-028 Store strobe and data:
- mem_wstrb_o = size mask (B 0x01, H 0x03, W 0x0F, D 0xFF) shifted left by wdata_i[2:0].
- mem_wdata_o = store_data_i shifted left by 8*wdata_i[2:0].
- mem_we_o=1.
REQ-029 Loads drive mem_we_o=0 and mem_wstrb_o=0.
REQ-030 Load result:
- on ack, register (mem_rdata_i >> 8*wdata_i[2:0]), truncated to the access size.
- sign-extend for B/H/W; zero-extend for BU/HU/WU.
- D is passed through unchanged.
REQ-031 In DONE, a load SHALL drive wdata_o = the registered result and wreg_o=wreg_i; a store SHALL drive wreg_o=0 and wdata_o=wdata_i.
REQ-032 Misalignment rule: H requires addr[0]=0; W requires addr[1:0]=0; D requires addr[2:0]=0.
REQ-033 On a misaligned access in IDLE:
- misalign_o=1 and wreg_o=0 for that cycle.
- no memory request, no stall; the FSM stays in IDLE.
REQ-034 On timeout, in the DONE cycle: bus_err_o=1, wreg_o=0, and no load data is written back.
REQ-035 misalign_o and bus_err_o SHALL each be single-cycle pulses.
REQ-036 funct3_i=111 with LOAD SHALL be treated as non-memory: wreg_o=0, no request.
REQ-037 A bubble (opcode 0010011, rd 0, wdata 0) SHALL pass through as a non-memory op.

Reset
REQ-038 On rst=1 at a clock edge:
- state=IDLE; timeout counter=0; load result register=0.
REQ-039 While rst=1 the following SHALL be driven 0:
- mem_req_o, mem_we_o, mem_wstrb_o.
- stall_req_o, wreg_o, misalign_o, bus_err_o.
REQ-040 Reset asserted while in BUSY SHALL:
- abandon the access; mem_req_o=0 from that cycle.
- ignore any later mem_ack_i until a new request is issued.

Verification
REQ-041 LW, addr 0x1004, rdata 0xFFFFFFFF_80000000, ack on first BUSY cycle -> wdata_o=0xFFFFFFFF_FFFFFFFF in the DONE cycle; stall_req_o high for exactly 2 cycles.
REQ-042 SB, addr 0x2003, store_data 0xAB -> mem_addr_o=0x2000, mem_wstrb_o=0x08, mem_wdata_o[31:24]=0xAB, wreg_o=0 in DONE.
REQ-043 LHU, addr 0x3006, rdata 0x8001_0000_0000_0000, ack after 4 wait cycles -> wdata_o=0x8001; mem_req_o held high for 5 cycles.
REQ-044 LD, addr 0x4004 -> misalign_o=1 for 1 cycle, mem_req_o=0, stall_req_o=0, wreg_o=0.
REQ-045 LW with no ack, TIMEOUT=8 -> bus_err_o pulses after 8 BUSY cycles, wreg_o=0, FSM back in IDLE.
REQ-046 rst asserted on the 2nd BUSY cycle, with ack on the following cycle -> mem_req_o=0 and no writeback; the next non-memory op passes with zero stall.
